game_timer: RTL and testbench
=============================

# game_timer

Elapsed-game-time counter and 4-digit seven-segment driver for the Minesweeper top level. Consumes `main_state` from `main_fsm` and counts whole seconds while the game is in play. Drives `timer_stop` back into `main_fsm` when the time limit expires, which replaces the constant tie-off. Also scans the count onto the board's common-anode display.

## Interface
Parameters:
- `CLK_HZ`, 74_250_000: clock cycles per counted second.
- `SCAN_DIV`, 74_250: clock cycles per digit slot (1 kHz digit rate).
- `TIME_LIMIT`, 999: seconds value at which counting stops; legal range 1..9999.
- `ST_IDLE`, 3'd0: `main_state` code that clears the timer.
- `ST_PLAY`, 3'd3: `main_state` code in which the timer runs.

Ports:
- `clk` in 1: single clock, the 74.25 MHz domain. One clock only; there are no crossings.
- `rst` in 1: asynchronous, active-high reset.
- `main_state` in 3: game state from `main_fsm`.
- `seconds_bcd` out 16: elapsed seconds as four BCD digits; [3:0] is the units digit.
- `timer_stop` out 1: sticky; set when the limit is reached.
- `an` out 4: digit anodes, active-low; bit 0 is the rightmost digit.
- `seg` out 7: segments, active-low, ordered {g,f,e,d,c,b,a}.
- `dp` out 1: decimal point; constant 1 (off).

## Operation
- Internal state:
  - prescaler `psc` (0..CLK_HZ-1)
  - binary seconds `sec` (14 bit)
  - BCD mirror `seconds_bcd`
  - `stopped` flag, which drives `timer_stop`
  - `prev_play` register
  - scan counter (0..SCAN_DIV-1)
  - digit index `idx` (2 bit)
- Mode decode, evaluated every edge in this priority order:
  - **CLEAR** (`main_state==ST_IDLE`): `psc`, `sec` and `seconds_bcd` go to 0; `timer_stop` goes to 0.
  - **RUN** (`main_state==ST_PLAY` and not stopped):
    - On entry (`prev_play==0`), `psc` is loaded with 1, so the entry edge counts as the first cycle.
    - Otherwise `psc` increments.
    - When `psc==CLK_HZ-1`: `psc` goes to 0 and `sec` increments. `seconds_bcd` increments with decimal carry, e.g. 0x0099 becomes 0x0100.
  - **HOLD** (any other state, or stopped): all counters freeze. `psc` is not cleared until the next PLAY entry.
- Limit: on the increment edge where the new `sec` equals TIME_LIMIT, `stopped` and `timer_stop` are set on that same edge. The counter never exceeds TIME_LIMIT.
- Wrap-around cannot occur, because TIME_LIMIT ≤ 9999.
- Scan:
  - The scan counter free-runs in every state.
  - On its wrap, `idx` advances 0→1→2→3→0.
  - `an` equals `~(4'b1 << idx)`.
  - `seg` is the decode of the BCD digit `idx`.
- Decode values: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10. Blank is 7'h7F.
- Leading-zero blanking: a digit is blank if it and every higher digit are 0. Digit 0 is never blanked.
- `an` and `seg` are registered and always change on the same edge.

## Timing
- Reset values: `seconds_bcd`=0, `timer_stop`=0, `an`=4'hF, `seg`=7'h7F, `dp`=1, `psc`=0, `idx`=0, `prev_play`=0.
- Reset is asynchronous and takes effect immediately, including mid-count or mid-scan.
- First increment: `seconds_bcd` becomes 1 on the CLK_HZ-th consecutive rising edge that samples `ST_PLAY`.
- Each later increment follows exactly CLK_HZ edges after the previous one.
- Leaving PLAY and re-entering without passing IDLE:
  - `sec` is kept.
  - `psc` restarts.
  - The next increment comes CLK_HZ edges after re-entry.
- `timer_stop` latency: 0 cycles after the limiting increment, because both are registered on the same edge.
- `timer_stop` stays high through WIN/LOST and any non-IDLE state. It clears on the first edge that samples ST_IDLE.
- IDLE and PLAY are mutually exclusive codes, so no simultaneous clear/run case exists.
- If IDLE is sampled on the increment edge, IDLE wins and the counter clears.
- Display:
  - `an`/`seg` update on the edge after the scan counter reaches SCAN_DIV-1.
  - Each digit is held for exactly SCAN_DIV cycles.
  - A new count is visible from the next slot boundary.

## Test plan
Bench parameters: CLK_HZ=10, SCAN_DIV=4, TIME_LIMIT=12.

- **Reset:** reset, then hold IDLE for 20 cycles -> `an`=F only until the first scan wrap. After that, digit 0 shows 7'h40 and digits 1–3 show 7'h7F. `seconds_bcd`=0 and `timer_stop`=0 throughout.
- **Counting and carry:** IDLE→PLAY for 35 cycles.
  - `seconds_bcd` reads 1 at PLAY edge 10, 2 at edge 20 and 3 at edge 30.
  - Continuing to 100 edges in PLAY gives 0x0010, which checks the BCD carry.
- **Pause and resume:** PLAY for 15 cycles, another state for 50, then PLAY again -> the value holds at 1 while not in PLAY. It becomes 2 exactly 10 edges after re-entry, not 5.
- **Limit:** PLAY for 200 cycles -> `seconds_bcd`=0x0012 and `timer_stop` rises on PLAY edge 120. Nothing changes afterwards. Going to IDLE clears both on the next edge.
- **Scan and blanking:** at `seconds_bcd`=0x0012 -> over 16 cycles, `an` cycles E,D,B,7. `seg` shows 7'h24, 7'h79, 7'h7F, 7'h7F, with `an` and `seg` switching on the same edge.
- **Reset mid-operation:** assert `rst` asynchronously, between clock edges, at count 7 during PLAY -> all outputs take their reset values immediately. After release with PLAY held, the count restarts from 0 and the first increment arrives 10 edges later.

Source files
------------

// File: rtl/game_timer.sv
// game_timer: elapsed-seconds counter for the Minesweeper top level.
// Counts whole seconds while main_fsm reports PLAY and raises a sticky
// timer_stop at the time limit. It also multiplexes the BCD count onto a
// 4-digit common-anode seven-segment display with leading-zero blanking.
module game_timer #(
  parameter int         CLK_HZ     = 74_250_000,
  parameter int         SCAN_DIV   = 74_250,
  parameter int         TIME_LIMIT = 999,
  parameter logic [2:0] ST_IDLE    = 3'd0,
  parameter logic [2:0] ST_PLAY    = 3'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  main_state,
  output logic [15:0] seconds_bcd,
  output logic        timer_stop,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int PSC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SCN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST  = PSC_W'(CLK_HZ - 1);
  localparam logic [SCN_W-1:0] SCN_LAST  = SCN_W'(SCAN_DIV - 1);
  localparam logic [13:0]      SEC_LIMIT = 14'(TIME_LIMIT);

  // Add one to a four-digit packed BCD value, rippling the decimal carry.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Active-low segment pattern {g,f,e,d,c,b,a} for one BCD digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  logic [PSC_W-1:0] psc, psc_nxt;
  logic [13:0]      sec, sec_nxt;
  logic [15:0]      bcd_nxt;
  logic             stopped, stop_nxt;
  logic             prev_play;
  logic             is_idle, is_play;

  logic [SCN_W-1:0] scan_cnt;
  logic [1:0]       idx;
  logic [3:0]       digit;
  logic             blank;

  assign timer_stop = stopped;
  assign dp         = 1'b1;

  // Mode decode: IDLE clears, PLAY (not stopped) runs, anything else holds.
  always_comb begin
    is_idle  = (main_state == ST_IDLE);
    is_play  = (main_state == ST_PLAY);
    psc_nxt  = psc;
    sec_nxt  = sec;
    bcd_nxt  = seconds_bcd;
    stop_nxt = stopped;
    if (is_idle) begin
      psc_nxt  = '0;
      sec_nxt  = '0;
      bcd_nxt  = '0;
      stop_nxt = 1'b0;
    end else if (is_play && !stopped) begin
      if (!prev_play) begin
        // The entry edge already counts as the first cycle of the second.
        psc_nxt = PSC_W'(1);
      end else if (psc == PSC_LAST) begin
        psc_nxt = '0;
        sec_nxt = sec + 14'd1;
        bcd_nxt = bcd_inc(seconds_bcd);
        if (sec + 14'd1 == SEC_LIMIT) stop_nxt = 1'b1;
      end else begin
        psc_nxt = psc + PSC_W'(1);
      end
    end
  end

  // Second counter, BCD mirror and limit flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc         <= '0;
      sec         <= '0;
      seconds_bcd <= '0;
      stopped     <= 1'b0;
      prev_play   <= 1'b0;
    end else begin
      psc         <= psc_nxt;
      sec         <= sec_nxt;
      seconds_bcd <= bcd_nxt;
      stopped     <= stop_nxt;
      prev_play   <= is_play;
    end
  end

  // Select the digit for the current slot; blank it when it and all higher digits are zero.
  always_comb begin
    digit = seconds_bcd[idx*4 +: 4];
    blank = 1'b0;
    case (idx)
      2'd1:    blank = (seconds_bcd[15:4] == 12'd0);
      2'd2:    blank = (seconds_bcd[15:8] == 8'd0);
      2'd3:    blank = (seconds_bcd[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
  end

  // Free-running digit scan; anodes and segments load together at each slot boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
      an       <= 4'hF;
      seg      <= 7'h7F;
    end else if (scan_cnt == SCN_LAST) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
      an       <= ~(4'b0001 << idx);
      seg      <= blank ? 7'h7F : seg_decode(digit);
    end else begin
      scan_cnt <= scan_cnt + SCN_W'(1);
    end
  end

endmodule

// File: tb/tb_game_timer.sv
// Testbench for game_timer with a small second-level reference model.
module tb_game_timer;
  localparam int         CLK_HZ     = 10;
  localparam int         SCAN_DIV   = 4;
  localparam int         TIME_LIMIT = 12;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PLAY    = 3'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  main_state = ST_IDLE;
  logic [15:0] seconds_bcd;
  logic        timer_stop;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: seconds value, run length since PLAY entry, scan edge count.
  int         m_sec, m_base, m_run, m_edges;
  bit         m_stop, m_prev;
  logic [3:0] m_an;
  logic [6:0] m_seg;

  game_timer #(
    .CLK_HZ(CLK_HZ), .SCAN_DIV(SCAN_DIV), .TIME_LIMIT(TIME_LIMIT),
    .ST_IDLE(ST_IDLE), .ST_PLAY(ST_PLAY)
  ) dut (
    .clk(clk), .rst(rst), .main_state(main_state),
    .seconds_bcd(seconds_bcd), .timer_stop(timer_stop),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bcd_of(input int v);
    logic [15:0] r;
    r[3:0]   = 4'((v) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int v, input int d);
    int p, dig;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    dig = (v / p) % 10;
    if (d > 0 && v < p) return 7'h7F;
    case (dig)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic model_reset();
    m_sec = 0; m_base = 0; m_run = 0; m_edges = 0;
    m_stop = 0; m_prev = 0; m_an = 4'hF; m_seg = 7'h7F;
  endtask

  // Apply one state for one clock edge and advance the model across that edge.
  task automatic tick(input logic [2:0] st);
    int d;
    main_state = st;
    m_edges++;
    if (m_edges % SCAN_DIV == 0) begin
      d     = ((m_edges / SCAN_DIV) - 1) % 4;
      m_an  = ~(4'b0001 << d);
      m_seg = seg_of(m_sec, d);
    end
    if (st == ST_IDLE) begin
      m_sec = 0; m_stop = 0;
    end else if (st == ST_PLAY && !m_stop) begin
      if (!m_prev) begin m_base = m_sec; m_run = 0; end
      m_run++;
      m_sec = m_base + m_run / CLK_HZ;
      if (m_sec == TIME_LIMIT) m_stop = 1;
    end
    m_prev = (st == ST_PLAY);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({seconds_bcd, timer_stop, an, seg, dp} !== {16'h0, 1'b0, 4'hF, 7'h7F, 1'b1})
      $display("FAIL reset_values: got bcd=%h stop=%b an=%h seg=%h dp=%b", seconds_bcd, timer_stop, an, seg, dp);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 1; i <= 20; i++) begin
      tick(ST_IDLE);
      n_chk++;
      if ({seconds_bcd, timer_stop, an, seg} !== {16'h0, 1'b0, m_an, m_seg})
        $display("FAIL reset_idle[%0d]: got bcd=%h stop=%b an=%h seg=%h want 0000 0 %h %h", i, seconds_bcd, timer_stop, an, seg, m_an, m_seg);
      else n_pass++;
      if (i < SCAN_DIV) begin
        n_chk++;
        if (an !== 4'hF) $display("FAIL reset_an_dark[%0d]: an=%h want f", i, an);
        else n_pass++;
      end
      if (i == SCAN_DIV) begin
        n_chk++;
        if ({an, seg} !== {4'hE, 7'h40}) $display("FAIL reset_first_slot: an=%h seg=%h want e 40", an, seg);
        else n_pass++;
      end
    end
  endtask

  task automatic test_counting();
    tick(ST_IDLE);
    for (int i = 1; i <= 100; i++) begin
      tick(ST_PLAY);
      n_chk++;
      if ({seconds_bcd, timer_stop} !== {bcd_of(m_sec), m_stop})
        $display("FAIL count_model[%0d]: got %h/%b want %h/%b", i, seconds_bcd, timer_stop, bcd_of(m_sec), m_stop);
      else n_pass++;
      if (i == 9 || i == 10 || i == 20 || i == 30 || i == 100) begin
        n_chk++;
        if (seconds_bcd !== ((i == 100) ? 16'h0010 : 16'(i / 10)))
          $display("FAIL count_edge[%0d]: got %h want %h", i, seconds_bcd, (i == 100) ? 16'h0010 : 16'(i / 10));
        else n_pass++;
      end
    end
  endtask

  task automatic test_pause_resume();
    tick(ST_IDLE);
    for (int i = 0; i < 15; i++) tick(ST_PLAY);
    for (int i = 1; i <= 50; i++) begin
      tick(3'd5);
      n_chk++;
      if (seconds_bcd !== 16'h0001) $display("FAIL pause_hold[%0d]: got %h want 0001", i, seconds_bcd);
      else n_pass++;
    end
    for (int i = 1; i <= 10; i++) begin
      tick(ST_PLAY);
      n_chk++;
      if (seconds_bcd !== ((i == 10) ? 16'h0002 : 16'h0001) || seconds_bcd !== bcd_of(m_sec))
        $display("FAIL resume[%0d]: got %h want %h", i, seconds_bcd, (i == 10) ? 16'h0002 : 16'h0001);
      else n_pass++;
    end
  endtask

  task automatic test_limit();
    tick(ST_IDLE);
    for (int i = 1; i <= 200; i++) begin
      tick(ST_PLAY);
      n_chk++;
      if (i < 120 && (timer_stop !== 1'b0 || seconds_bcd !== bcd_of(i / 10)))
        $display("FAIL limit_pre[%0d]: got %h/%b want %h/0", i, seconds_bcd, timer_stop, bcd_of(i / 10));
      else if (i >= 120 && {seconds_bcd, timer_stop} !== {16'h0012, 1'b1})
        $display("FAIL limit_post[%0d]: got %h/%b want 0012/1", i, seconds_bcd, timer_stop);
      else n_pass++;
    end
    for (int i = 1; i <= 5; i++) begin
      tick(3'd4);
      n_chk++;
      if ({seconds_bcd, timer_stop} !== {16'h0012, 1'b1})
        $display("FAIL limit_win[%0d]: got %h/%b want 0012/1", i, seconds_bcd, timer_stop);
      else n_pass++;
    end
  endtask

  task automatic test_scan();
    logic [6:0] want;
    int         seen;
    seen = 0;
    for (int i = 1; i <= 16; i++) begin
      tick(3'd4);
      n_chk++;
      if ({an, seg} !== {m_an, m_seg})
        $display("FAIL scan_model[%0d]: an=%h seg=%h want %h %h", i, an, seg, m_an, m_seg);
      else n_pass++;
      case (an)
        4'hE: begin want = 7'h24; seen |= 1; end
        4'hD: begin want = 7'h79; seen |= 2; end
        4'hB: begin want = 7'h7F; seen |= 4; end
        4'h7: begin want = 7'h7F; seen |= 8; end
        default: want = 7'h00;
      endcase
      n_chk++;
      if (seg !== want) $display("FAIL scan_pair[%0d]: an=%h seg=%h want seg %h", i, an, seg, want);
      else n_pass++;
    end
    n_chk++;
    if (seen !== 15) $display("FAIL scan_all_digits: seen mask=%h want f", seen);
    else n_pass++;
    tick(ST_IDLE);
    n_chk++;
    if ({seconds_bcd, timer_stop} !== {16'h0000, 1'b0})
      $display("FAIL idle_clear: got %h/%b want 0000/0", seconds_bcd, timer_stop);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    tick(ST_IDLE);
    for (int i = 0; i < 73; i++) tick(ST_PLAY);
    n_chk++;
    if (seconds_bcd !== 16'h0007) $display("FAIL midrst_pre: got %h want 0007", seconds_bcd);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({seconds_bcd, timer_stop, an, seg, dp} !== {16'h0, 1'b0, 4'hF, 7'h7F, 1'b1})
      $display("FAIL midrst_async: got bcd=%h stop=%b an=%h seg=%h dp=%b", seconds_bcd, timer_stop, an, seg, dp);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 1; i <= 10; i++) begin
      tick(ST_PLAY);
      n_chk++;
      if ({seconds_bcd, an, seg} !== {((i == 10) ? 16'h0001 : 16'h0000), m_an, m_seg})
        $display("FAIL midrst_restart[%0d]: got %h an=%h seg=%h want %h %h %h", i, seconds_bcd, an, seg, (i == 10) ? 16'h0001 : 16'h0000, m_an, m_seg);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [2:0] st;
    int         len;
    tick(ST_IDLE);
    for (int s = 0; s < 40; s++) begin
      case ($urandom_range(0, 5))
        0:       st = ST_IDLE;
        1:       st = 3'd4;
        2:       st = 3'd5;
        default: st = ST_PLAY;
      endcase
      len = $urandom_range(1, 45);
      for (int i = 0; i < len; i++) begin
        tick(st);
        n_chk++;
        if ({seconds_bcd, timer_stop, an, seg, dp} !== {bcd_of(m_sec), m_stop, m_an, m_seg, 1'b1})
          $display("FAIL random[%0d.%0d]: got %h/%b an=%h seg=%h want %h/%b %h %h", s, i, seconds_bcd, timer_stop, an, seg, bcd_of(m_sec), m_stop, m_an, m_seg);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_counting();
    test_pause_resume();
    test_limit();
    test_scan();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
